// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the 8-bit core.
// Drives the external combinational ALU and commits its result and flags in EXEC.
module control_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              rom_en,
    input  logic [15:0]       instr_in,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_p,
    input  logic              alu_z,
    input  logic              alu_s,
    input  logic              alu_c,
    input  logic              alu_ov,
    output logic [DATA_W-1:0] acc_out,
    output logic [4:0]        flags_out,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_ADDC = 4'd8;
    localparam logic [3:0] OP_SUBC = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_JZ   = 4'd12;
    localparam logic [3:0] OP_JC   = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        flags_q, flags_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];

    logic [3:0] opcode;
    logic       is_alu;
    logic       is_arith;
    logic       unused_ir_bit;

    assign opcode        = ir_q[15:12];
    assign is_alu        = (opcode < OP_MOV);
    assign is_arith      = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                           (opcode == OP_ADDC) || (opcode == OP_SUBC);
    assign unused_ir_bit = ir_q[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    // Flags are {OV, C, S, Z, P}; only EXEC writes architectural state,
    // and a taken branch simply overwrites the increment done in DECODE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        rom_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_en  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = instr_in;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    acc_d        = alu_out;
                    flags_d[2:0] = {alu_s, alu_z, alu_p};
                    if (is_arith) flags_d[4:3] = {alu_ov, alu_c};
                end
                case (opcode)
                    OP_MOV: regs_d[ir_q[9:8]] = acc_q;
                    OP_JMP: pc_d = ADDR_W'(ir_q[7:0]);
                    OP_JZ:  if (flags_q[1]) pc_d = ADDR_W'(ir_q[7:0]);
                    OP_JC:  if (flags_q[3]) pc_d = ADDR_W'(ir_q[7:0]);
                    default: ;
                endcase
                if (opcode == OP_HALT) state_d = S_HALT;
                else if (run)          state_d = S_FETCH;
                else                   state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_addr   = pc_q;
    assign alu_a     = acc_q;
    assign alu_b     = ir_q[11] ? DATA_W'(ir_q[7:0]) : regs_q[ir_q[9:8]];
    assign alu_op    = is_alu ? opcode : 4'd0;
    assign alu_c_in  = flags_q[3];
    assign acc_out   = acc_q;
    assign flags_out = flags_q;
    assign halted    = (state_q == S_HALT);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: behavioural ROM and ALU, expected
// per-instruction results queued by the stimulus and checked by a monitor.
module tb_control_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic [ADDR_W-1:0] pc_addr;
    logic              rom_en;
    logic [15:0]       instr_in;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]        alu_op;
    logic              alu_c_in;
    logic              alu_p, alu_z, alu_s, alu_c, alu_ov;
    logic [DATA_W-1:0] acc_out;
    logic [4:0]        flags_out;
    logic              halted, busy;

    typedef struct {
        logic [7:0] acc;
        logic [4:0] flags;
        logic [7:0] pc;
        logic       busy;
        logic       halted;
    } exp_t;

    exp_t       expQ[$];
    logic [15:0] rom [256];
    int         checks;
    int         failures;
    int         phase;

    control_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .pc_addr(pc_addr), .rom_en(rom_en), .instr_in(instr_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
        .alu_out(alu_out), .alu_p(alu_p), .alu_z(alu_z), .alu_s(alu_s),
        .alu_c(alu_c), .alu_ov(alu_ov),
        .acc_out(acc_out), .flags_out(flags_out), .halted(halted), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM answers one clock after the read strobe.
    always @(posedge clk) begin
        if (rom_en) instr_in <= rom[pc_addr];
    end

    // Reference ALU. Non-arithmetic ops drive C and OV high so that any
    // wrongful update of those flags shows up in the scoreboard.
    always_comb begin
        logic [8:0] r;
        logic       arith;
        r     = 9'd0;
        arith = 1'b0;
        case (alu_op)
            4'd0: r = {1'b0, alu_b};
            4'd1: r = {1'b0, alu_a & alu_b};
            4'd2: r = {1'b0, alu_a | alu_b};
            4'd3: r = {1'b0, alu_a ^ alu_b};
            4'd4: begin r = {1'b0, alu_a} + {1'b0, alu_b}; arith = 1'b1; end
            4'd5: begin r = {1'b0, alu_a} - {1'b0, alu_b}; arith = 1'b1; end
            4'd6: r = {1'b0, alu_a} + 9'd1;
            4'd7: r = {1'b0, ~alu_a};
            4'd8: begin r = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in}; arith = 1'b1; end
            4'd9: begin r = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_c_in}; arith = 1'b1; end
            default: r = 9'd0;
        endcase
        alu_out = r[7:0];
        alu_z   = (r[7:0] == 8'd0);
        alu_s   = r[7];
        alu_p   = ~^r[7:0];
        alu_c   = arith ? r[8] : 1'b1;
        if (!arith)
            alu_ov = 1'b1;
        else if (alu_op == 4'd4 || alu_op == 4'd8)
            alu_ov = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]);
        else
            alu_ov = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]);
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic imm,
                                        input logic [1:0] r, input logic [7:0] v);
        return {op, imm, 1'b0, r, v};
    endfunction

    task automatic pushExp(input logic [7:0] acc, input logic [4:0] flags,
                           input logic [7:0] pc, input logic bsy, input logic hlt);
        exp_t e;
        e.acc = acc; e.flags = flags; e.pc = pc; e.busy = bsy; e.halted = hlt;
        expQ.push_back(e);
    endtask

    // Monitor: the cycle three negedges after a FETCH is the one right after EXEC.
    initial begin
        phase = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
            end else begin
                if (phase > 0) begin
                    phase--;
                    if (phase == 0) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected retire", 16'd1, 16'd0);
                        end else begin
                            exp_t e;
                            e = expQ.pop_front();
                            checkOutput("acc", acc_out, e.acc);
                            checkOutput("flags", flags_out, e.flags);
                            checkOutput("pc", pc_addr, e.pc);
                            checkOutput("busy", busy, e.busy);
                            checkOutput("halted", halted, e.halted);
                        end
                    end
                end
                if (rom_en) phase = 3;
            end
        end
    end

    task automatic loadRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic resetDut();
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset acc", acc_out, 16'd0);
        checkOutput("reset flags", flags_out, 16'd0);
        checkOutput("reset pc", pc_addr, 16'd0);
        checkOutput("reset rom_en", rom_en, 16'd0);
        checkOutput("reset halted", halted, 16'd0);
        checkOutput("reset busy", busy, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("queue drained", 16'(expQ.size()), 16'd0);
        expQ.delete();
    endtask

    task automatic applyStimulus();
        run = 1'b1;
        waitDrain();
    endtask

    task automatic checkHaltHolds();
        repeat (5) @(negedge clk);
        checkOutput("halt sticky", halted, 16'd1);
        checkOutput("halt busy", busy, 16'd0);
        checkOutput("halt rom_en", rom_en, 16'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        loadRom();

        // LD #7F, ADD #01: signed overflow into 0x80
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'h7F);
        rom[1] = enc(4'd4, 1'b1, 2'd0, 8'h01);
        pushExp(8'h7F, 5'b00000, 8'h01, 1'b1, 1'b0);
        pushExp(8'h80, 5'b10100, 8'h02, 1'b1, 1'b0);
        pushExp(8'h80, 5'b10100, 8'h03, 1'b0, 1'b1);
        applyStimulus();
        checkHaltHolds();

        // LD #FF, ADD #01, ADDC #00: carry out, then carry in
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'hFF);
        rom[1] = enc(4'd4, 1'b1, 2'd0, 8'h01);
        rom[2] = enc(4'd8, 1'b1, 2'd0, 8'h00);
        pushExp(8'hFF, 5'b00101, 8'h01, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'h02, 1'b1, 1'b0);
        pushExp(8'h01, 5'b00000, 8'h03, 1'b1, 1'b0);
        pushExp(8'h01, 5'b00000, 8'h04, 1'b0, 1'b1);
        applyStimulus();

        // LD #05, MOV R2, LD #03, SUB R2, LD R2
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'h05);
        rom[1] = enc(4'd10, 1'b0, 2'd2, 8'h00);
        rom[2] = enc(4'd0, 1'b1, 2'd0, 8'h03);
        rom[3] = enc(4'd5, 1'b0, 2'd2, 8'h00);
        rom[4] = enc(4'd0, 1'b0, 2'd2, 8'h00);
        pushExp(8'h05, 5'b00001, 8'h01, 1'b1, 1'b0);
        pushExp(8'h05, 5'b00001, 8'h02, 1'b1, 1'b0);
        pushExp(8'h03, 5'b00001, 8'h03, 1'b1, 1'b0);
        pushExp(8'hFE, 5'b01100, 8'h04, 1'b1, 1'b0);
        pushExp(8'h05, 5'b01001, 8'h05, 1'b1, 1'b0);
        pushExp(8'h05, 5'b01001, 8'h06, 1'b0, 1'b1);
        applyStimulus();

        // LD #00, JZ 0x10 taken
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'h00);
        rom[1] = enc(4'd12, 1'b1, 2'd0, 8'h10);
        pushExp(8'h00, 5'b00011, 8'h01, 1'b1, 1'b0);
        pushExp(8'h00, 5'b00011, 8'h10, 1'b1, 1'b0);
        pushExp(8'h00, 5'b00011, 8'h11, 1'b0, 1'b1);
        applyStimulus();

        // LD #01, JZ 0x10 falls through
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'h01);
        rom[1] = enc(4'd12, 1'b1, 2'd0, 8'h10);
        pushExp(8'h01, 5'b00000, 8'h01, 1'b1, 1'b0);
        pushExp(8'h01, 5'b00000, 8'h02, 1'b1, 1'b0);
        pushExp(8'h01, 5'b00000, 8'h03, 1'b0, 1'b1);
        applyStimulus();

        // JC not taken, set carry, JMP to 0xFF, wrap to 0x00, JC taken
        resetDut();
        loadRom();
        rom[8'h00] = enc(4'd13, 1'b1, 2'd0, 8'h20);
        rom[8'h01] = enc(4'd0, 1'b1, 2'd0, 8'hFF);
        rom[8'h02] = enc(4'd4, 1'b1, 2'd0, 8'h01);
        rom[8'h03] = enc(4'd11, 1'b1, 2'd0, 8'hFF);
        rom[8'hFF] = enc(4'd14, 1'b0, 2'd0, 8'h00);
        pushExp(8'h00, 5'b00000, 8'h01, 1'b1, 1'b0);
        pushExp(8'hFF, 5'b00101, 8'h02, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'h03, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'hFF, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'h00, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'h20, 1'b1, 1'b0);
        pushExp(8'h00, 5'b01011, 8'h21, 1'b0, 1'b1);
        applyStimulus();

        // Drop run during DECODE of INK, then resume
        resetDut();
        loadRom();
        rom[0] = enc(4'd0, 1'b1, 2'd0, 8'h10);
        rom[1] = enc(4'd6, 1'b0, 2'd0, 8'h00);
        rom[2] = enc(4'd7, 1'b0, 2'd0, 8'h00);
        pushExp(8'h10, 5'b00000, 8'h01, 1'b1, 1'b0);
        pushExp(8'h11, 5'b00001, 8'h02, 1'b0, 1'b0);
        run  = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && seen < 2; i++) begin
            @(negedge clk);
            if (rom_en) seen++;
        end
        checkOutput("INK fetch seen", 16'(seen), 16'd2);
        @(negedge clk);
        run = 1'b0;
        waitDrain();
        repeat (4) @(negedge clk);
        checkOutput("idle pc hold", pc_addr, 16'h02);
        checkOutput("idle busy", busy, 16'd0);
        checkOutput("idle rom_en", rom_en, 16'd0);
        pushExp(8'hEE, 5'b00101, 8'h03, 1'b1, 1'b0);
        pushExp(8'hEE, 5'b00101, 8'h04, 1'b0, 1'b1);
        applyStimulus();

        // Reset asserted mid-EXEC of ADD discards the instruction
        resetDut();
        loadRom();
        rom[0] = enc(4'd4, 1'b1, 2'd0, 8'h05);
        run  = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && seen < 1; i++) begin
            @(negedge clk);
            if (rom_en) seen++;
        end
        checkOutput("ADD fetch seen", 16'(seen), 16'd1);
        repeat (2) @(negedge clk);
        checkOutput("EXEC busy", busy, 16'd1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        checkOutput("async acc", acc_out, 16'd0);
        checkOutput("async flags", flags_out, 16'd0);
        checkOutput("async busy", busy, 16'd0);
        checkOutput("async pc", pc_addr, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post reset acc", acc_out, 16'd0);
        checkOutput("post reset idle", busy, 16'd0);
        checkOutput("post reset halted", halted, 16'd0);
        checkOutput("post reset pc", pc_addr, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer for the 8-bit core. It sits directly upstream of the combinational ALU and owns the program counter, instruction register, accumulator, a 4-entry register file and the flag register. It drives the ALU's a, b, alu_op and C_in inputs, and registers the ALU's out, P, Z, S, C and OV back into the accumulator and flags.

## Interface
- DATA_W, 8, data and ALU width; the ALU is instantiated with ALU_rozm_data = DATA_W
- ADDR_W, 8, program address width
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
- pc_addr  out  ADDR_W  program ROM address
- rom_en  out  1  ROM read strobe; the ROM returns data one clock later
- instr_in  in  16  ROM data: [15:12] opcode, [11] imm, [9:8] reg index, [7:0] imm8
- alu_a  out  DATA_W  = acc
- alu_b  out  DATA_W  = imm8 if IR[11], else R[IR[9:8]]
- alu_op  out  4  ALU operation code
- alu_c_in  out  1  = flag C
- alu_out  in  DATA_W  ALU result
- alu_p, alu_z, alu_s, alu_c, alu_ov  in  1 each  ALU flags
- acc_out  out  DATA_W  accumulator
- flags_out  out  5  {OV, C, S, Z, P}
- halted  out  1  core is in HALT
- busy  out  1  state is not IDLE and not HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: go to FETCH if run = 1.
- FETCH: pc_addr = PC, rom_en = 1, then go to DECODE.
- DECODE: IR <= instr_in, PC <= PC + 1 (wraps 0xFF -> 0x00), then go to EXEC.
- Opcodes 0000–1001 are ALU ops, passed unchanged on alu_op:
  - LD, AND, OR, XOR, ADD, SUB, INK, NOT, ADDC, SUBC.
  - In EXEC: acc <= alu_out; P, Z, S <= ALU flags.
  - C and OV are updated only for ADD, SUB, ADDC and SUBC; all other ops keep them.
  - For SUB/SUBC, C is the borrow bit as produced by the ALU.
- 1010 MOV: R[IR[9:8]] <= acc. Flags unchanged.
- 1011 JMP: PC <= imm8.
- 1100 JZ: PC <= imm8 if Z = 1.
- 1101 JC: PC <= imm8 if C = 1.
- 1110 NOP: no state change except sequencing.
- 1111 HALT: go to HALT.
- For opcodes 1010–1111, alu_op = 0000 and acc/flags are not written.
- Leaving EXEC: go to FETCH if run = 1, else IDLE.
- HALT: absorbing; only rst_n leaves it. halted = 1.
- A taken branch overrides the DECODE increment. A branch to the current instruction's own address is legal (tight loop).
- alu_a, alu_b and alu_op are driven from IR in every state. Only EXEC commits results.

## Timing
- Every instruction takes exactly 3 clocks (FETCH, DECODE, EXEC). HALT takes 3 clocks to reach the HALT state.
- A result or flag is visible on acc_out/flags_out the cycle after EXEC.
- A register written by MOV is readable as alu_b by the next instruction without a stall.
- A branch target is fetched in the cycle after EXEC.
- run is sampled in IDLE and at the end of EXEC only. Deasserting run mid-instruction completes that instruction.
- Reset (asynchronous, any state): state = IDLE; PC = 0; IR = 0; acc = 0; R0–R3 = 0; flags = 00000.
  - Outputs during and after reset: rom_en = 0, halted = 0, busy = 0, pc_addr = 0.
  - Reset mid-EXEC: the instruction is discarded and no partial write occurs.

## Test plan
- Reset, then run = 1 with LD #0x7F, ADD #0x01 -> acc = 0x80, flags {OV=1, C=0, S=1, Z=0, P=0}. ADD commits in clock 6 after run.
- LD #0xFF, ADD #0x01, ADDC #0x00 -> after ADD: acc = 0x00, Z = 1, C = 1. After ADDC: acc = 0x01, C = 0.
- LD #0x05, MOV R2, LD #0x03, SUB R2 -> acc = 0xFE, C = 1 (borrow), S = 1; R2 = 0x05.
- LD #0x00, JZ 0x10 -> pc_addr = 0x10 in the FETCH after EXEC. Same sequence with acc = 0x01 -> falls through to 0x02. JMP at 0xFF wraps correctly.
- Drop run during DECODE of INK -> INK commits, the core enters IDLE, pc_addr holds. Reassert run -> resumes at the next address.
- HALT -> halted = 1 and busy = 0 until reset. Assert rst_n low mid-EXEC of ADD -> acc and flags stay 0 and the state is IDLE.
